// File: rtl/sid_pkg.sv
// Shared types and constants for the SID voice/mix multiply-accumulate scheduler.
package sid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISS0,
        ISS1,
        ISS2,
        ISS3,
        DRAIN,
        FIN
    } sched_state_e;

    localparam int ENV_SHIFT = 8;
    localparam int VOL_SHIFT = 4;

    localparam int VOICE_W = 12;
    localparam int ENV_W   = 8;
    localparam int MIX_W   = 16;
    localparam int VOL_W   = 4;

    localparam int MUL_W  = 16;
    localparam int PROD_W = 32;

endpackage

// File: rtl/sid_mul16.sv
// Registered 16x16 multiplier: signed A times unsigned B, one cycle of latency.
module sid_mul16
    import sid_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [MUL_W-1:0]  a_i,
    input  logic [MUL_W-1:0]  b_i,
    output logic [PROD_W-1:0] p_o
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] p_d;
    logic [PROD_W-1:0] p_q;

    // The exact product fits in 32 signed bits, so a modulo-2^32 multiply of
    // the sign-extended A and zero-extended B gives the correct result.
    assign a_ext = {{(PROD_W-MUL_W){a_i[MUL_W-1]}}, a_i};
    assign b_ext = {{(PROD_W-MUL_W){1'b0}}, b_i};
    assign p_d   = a_ext * b_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/sid_mac_sched.sv
// Time-shares one multiplier to envelope three voices and volume-scale the mix.
// Optional OVERRUN counter of ignored strobes is built when SID_MAC_STATS_EN is defined.
module sid_mac_sched
    import sid_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLKen,
    input  logic [VOICE_W-1:0] VOICE0,
    input  logic [VOICE_W-1:0] VOICE1,
    input  logic [VOICE_W-1:0] VOICE2,
    input  logic [ENV_W-1:0]   ENV0,
    input  logic [ENV_W-1:0]   ENV1,
    input  logic [ENV_W-1:0]   ENV2,
    input  logic [MIX_W-1:0]   MIX,
    input  logic [VOL_W-1:0]   VOL,
    output logic [15:0]        AMP0,
    output logic [15:0]        AMP1,
    output logic [15:0]        AMP2,
    output logic [15:0]        OUTPUT,
    output logic               BUSY,
    output logic               DONE
`ifdef SID_MAC_STATS_EN
   ,output logic [7:0]         OVERRUN
`endif
);

    sched_state_e state_q, state_d;

    logic [VOICE_W-1:0] voice0_q, voice1_q, voice2_q;
    logic [ENV_W-1:0]   env0_q, env1_q, env2_q;
    logic [MIX_W-1:0]   mix_q;
    logic [VOL_W-1:0]   vol_q;
    logic [15:0]        amp0_q, amp1_q, amp2_q, out_q;

    logic [MUL_W-1:0]   mul_a;
    logic [MUL_W-1:0]   mul_b;
    logic [PROD_W-1:0]  product;
    logic               unused_prod_bits;

    // CLKen is a strobe, not a handshake: it is accepted only in IDLE and
    // silently dropped in every other state (including FIN).
    always_comb begin
        state_d = state_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            IDLE: if (CLKen) state_d = ISS0;
            ISS0: begin
                mul_a   = {voice0_q, {(MUL_W-VOICE_W){1'b0}}};
                mul_b   = {{(MUL_W-ENV_W){1'b0}}, env0_q};
                state_d = ISS1;
            end
            ISS1: begin
                mul_a   = {voice1_q, {(MUL_W-VOICE_W){1'b0}}};
                mul_b   = {{(MUL_W-ENV_W){1'b0}}, env1_q};
                state_d = ISS2;
            end
            ISS2: begin
                mul_a   = {voice2_q, {(MUL_W-VOICE_W){1'b0}}};
                mul_b   = {{(MUL_W-ENV_W){1'b0}}, env2_q};
                state_d = ISS3;
            end
            ISS3: begin
                mul_a   = mix_q;
                mul_b   = {{(MUL_W-VOL_W){1'b0}}, vol_q};
                state_d = DRAIN;
            end
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            voice0_q <= '0;
            voice1_q <= '0;
            voice2_q <= '0;
            env0_q   <= '0;
            env1_q   <= '0;
            env2_q   <= '0;
            mix_q    <= '0;
            vol_q    <= '0;
            amp0_q   <= '0;
            amp1_q   <= '0;
            amp2_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && CLKen) begin
                voice0_q <= VOICE0;
                voice1_q <= VOICE1;
                voice2_q <= VOICE2;
                env0_q   <= ENV0;
                env1_q   <= ENV1;
                env2_q   <= ENV2;
                mix_q    <= MIX;
                vol_q    <= VOL;
            end
            // Each capture picks up the product issued one state earlier.
            case (state_q)
                ISS1:    amp0_q <= product[ENV_SHIFT +: 16];
                ISS2:    amp1_q <= product[ENV_SHIFT +: 16];
                ISS3:    amp2_q <= product[ENV_SHIFT +: 16];
                DRAIN:   out_q  <= product[VOL_SHIFT +: 16];
                default: ;
            endcase
        end
    end

    sid_mul16 u_mul (
        .clk_i (CLK),
        .rst_i (RST),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (product)
    );

    assign unused_prod_bits = ^{product[PROD_W-1:ENV_SHIFT+16], product[VOL_SHIFT-1:0]};

    assign AMP0   = amp0_q;
    assign AMP1   = amp1_q;
    assign AMP2   = amp2_q;
    assign OUTPUT = out_q;
    assign BUSY   = (state_q != IDLE);
    assign DONE   = (state_q == FIN);

`ifdef SID_MAC_STATS_EN
    logic [7:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (CLKen && state_q != IDLE && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign OVERRUN = overrun_q;
`endif

endmodule

// File: tb/tb_sid_mac_sched.sv
// Self-checking bench for sid_mac_sched against a cycle-count/arithmetic reference model.
module tb_sid_mac_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLKen;
    logic [11:0] VOICE0, VOICE1, VOICE2;
    logic [7:0]  ENV0, ENV1, ENV2;
    logic [15:0] MIX;
    logic [3:0]  VOL;
    logic [15:0] AMP0, AMP1, AMP2, OUTPUT;
    logic        BUSY, DONE;
`ifdef SID_MAC_STATS_EN
    logic [7:0]  OVERRUN;
`endif

    always #5 CLK = ~CLK;

    sid_mac_sched dut (
        .CLK    (CLK),
        .RST    (RST),
        .CLKen  (CLKen),
        .VOICE0 (VOICE0),
        .VOICE1 (VOICE1),
        .VOICE2 (VOICE2),
        .ENV0   (ENV0),
        .ENV1   (ENV1),
        .ENV2   (ENV2),
        .MIX    (MIX),
        .VOL    (VOL),
        .AMP0   (AMP0),
        .AMP1   (AMP1),
        .AMP2   (AMP2),
        .OUTPUT (OUTPUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
`ifdef SID_MAC_STATS_EN
       ,.OVERRUN(OVERRUN)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase = cycles since the accepted strobe (0 = idle).
    int          m_phase = 0;
    logic [11:0] m_v [3];
    logic [7:0]  m_e [3];
    logic [15:0] m_mix;
    logic [3:0]  m_vol;
    logic [15:0] m_amp [3];
    logic [15:0] m_out;
    int          m_ovr = 0;

    function automatic logic [15:0] amp_ref(input logic [11:0] v, input logic [7:0] e);
        longint p;
        p = longint'($signed(v)) * 16 * longint'(e);
        return p[23:8];
    endfunction

    function automatic logic [15:0] out_ref(input logic [15:0] m, input logic [3:0] v);
        longint p;
        p = longint'($signed(m)) * longint'(v);
        return p[19:4];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_phase = 0;
            for (int k = 0; k < 3; k++) begin
                m_v[k] = '0; m_e[k] = '0; m_amp[k] = '0;
            end
            m_mix = '0; m_vol = '0; m_out = '0; m_ovr = 0;
        end else if (m_phase == 0) begin
            if (CLKen) begin
                m_v[0] = VOICE0; m_v[1] = VOICE1; m_v[2] = VOICE2;
                m_e[0] = ENV0;   m_e[1] = ENV1;   m_e[2] = ENV2;
                m_mix  = MIX;    m_vol  = VOL;
                m_phase = 1;
            end
        end else begin
            if (CLKen && m_ovr < 255) m_ovr++;
            m_phase = (m_phase == 6) ? 0 : m_phase + 1;
            case (m_phase)
                3: m_amp[0] = amp_ref(m_v[0], m_e[0]);
                4: m_amp[1] = amp_ref(m_v[1], m_e[1]);
                5: m_amp[2] = amp_ref(m_v[2], m_e[2]);
                6: m_out    = out_ref(m_mix, m_vol);
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check_eq("amp0",   32'(AMP0),   32'(m_amp[0]));
        check_eq("amp1",   32'(AMP1),   32'(m_amp[1]));
        check_eq("amp2",   32'(AMP2),   32'(m_amp[2]));
        check_eq("output", 32'(OUTPUT), 32'(m_out));
        check_eq("busy",   32'(BUSY),   32'(m_phase != 0));
        check_eq("done",   32'(DONE),   32'(m_phase == 6));
`ifdef SID_MAC_STATS_EN
        check_eq("overrun", 32'(OVERRUN), 32'(m_ovr));
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic rand_inputs();
        VOICE0 = 12'($urandom); VOICE1 = 12'($urandom); VOICE2 = 12'($urandom);
        ENV0   = 8'($urandom);  ENV1   = 8'($urandom);  ENV2   = 8'($urandom);
        MIX    = 16'($urandom); VOL    = 4'($urandom);
    endtask

    initial begin
        RST = 1'b1; CLKen = 1'b0;
        rand_inputs();
        repeat (2) step();
        check_eq("rst_amp0", 32'(AMP0), 32'h0);
        check_eq("rst_busy", 32'(BUSY), 32'h0);
        RST = 1'b0;
        step();

        // Extreme voice/envelope values and full-scale positive mix.
        VOICE0 = 12'h7FF; ENV0 = 8'hFF; VOICE1 = 12'h800; ENV1 = 8'h80;
        VOICE2 = 12'($urandom); ENV2 = 8'h00; MIX = 16'h7FFF; VOL = 4'hF;
        CLKen = 1'b1; step(); CLKen = 1'b0;
        rand_inputs();
        repeat (2) step();
        check_eq("c3_amp0_7f70", 32'(AMP0), 32'h7F70);
        step();
        check_eq("c4_amp1_c000", 32'(AMP1), 32'hC000);
        step();
        check_eq("c5_amp2_zero", 32'(AMP2), 32'h0);
        step();
        check_eq("c6_out_77ff", 32'(OUTPUT), 32'h77FF);
        check_eq("c6_done", 32'(DONE), 32'h1);
        step();
        check_eq("c7_done_low", 32'(DONE), 32'h0);

        // Full-scale negative mix at unit volume.
        MIX = 16'h8000; VOL = 4'h1;
        CLKen = 1'b1; step(); CLKen = 1'b0;
        repeat (5) step();
        check_eq("c6_out_f800", 32'(OUTPUT), 32'hF800);
        step();

        // Strobes in cycles 0, 2, 6 then 7: one schedule, then a second.
        rand_inputs();
        CLKen = 1'b1; step(); CLKen = 1'b0; step();
        CLKen = 1'b1; step(); CLKen = 1'b0; repeat (3) step();
        CLKen = 1'b1; step();
`ifdef SID_MAC_STATS_EN
        check_eq("ovr_two", 32'(OVERRUN), 32'd2);
`endif
        rand_inputs();
        step(); CLKen = 1'b0;
        check_eq("second_sched_busy", 32'(BUSY), 32'h1);
        repeat (7) step();

        // Reset in cycle 3 aborts; strobe in cycle 5 restarts.
        rand_inputs();
        CLKen = 1'b1; step(); CLKen = 1'b0; repeat (2) step();
        RST = 1'b1; step(); RST = 1'b0;
        check_eq("abort_amp0", 32'(AMP0), 32'h0);
        check_eq("abort_out",  32'(OUTPUT), 32'h0);
        check_eq("abort_busy", 32'(BUSY), 32'h0);
        check_eq("abort_done", 32'(DONE), 32'h0);
        step();
        rand_inputs();
        CLKen = 1'b1; step(); CLKen = 1'b0;
        repeat (7) step();

        // Reset together with a strobe: nothing starts.
        RST = 1'b1; CLKen = 1'b1; step(); RST = 1'b0; CLKen = 1'b0;
        check_eq("rst_beats_clken", 32'(BUSY), 32'h0);
        step();

        // Operand changes after cycle 0 must not leak into the schedule.
        VOICE0 = 12'h123; ENV0 = 8'hFF;
        CLKen = 1'b1; step(); CLKen = 1'b0;
        VOICE0 = 12'hE00; ENV0 = 8'h01;
        repeat (2) step();
        check_eq("latched_voice0", 32'(AMP0), 32'(amp_ref(12'h123, 8'hFF)));
        repeat (5) step();

        // Random traffic with occasional resets.
        repeat (500) begin
            RST   = ($urandom_range(0, 63) == 0);
            CLKen = ($urandom_range(0, 2) == 0);
            rand_inputs();
            step();
        end
        RST = 1'b0; CLKen = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
